store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer directly downstream of the store formatting stage (lane-replicated data plus byte enables).
- Accepts formatted stores in program order, queues them in a FIFO and drains them to the data-memory bus over a req/ack handshake, so the pipeline does not stall on slow memory writes.
- Exposes a word-address hit flag so the load path can stall on a pending same-word store.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
CW, $clog2(DEPTH+1), width of oCount (derived, not overridden)

Ports:
iCLK  input  1  clock; all state updates on rising edge
iRST  input  1  synchronous reset, active-high
iWrValid  input  1  store request from formatting stage
oWrReady  output  1  buffer can accept a store this cycle
iWrAddr  input  32  store byte address
iWrData  input  32  lane-replicated store data
iWrByteEnable  input  4  byte lanes to write
iWrException  input  1  misaligned-store flag from formatting stage
oMemReq  output  1  write request to data memory
iMemAck  input  1  memory accepted the head write
oMemAddr  output  32  word-aligned write address
oMemData  output  32  write data
oMemByteEnable  output  4  write byte lanes
iLdAddr  input  32  load address from load path
oLdHit  output  1  a buffered store targets the load's word
oCount  output  CW  valid entries
oEmpty  output  1  oCount == 0
oFull  output  1  oCount == DEPTH

Behaviour:
- Reset (iRST high at an edge):
  - all entries invalid; head and tail pointers 0; oCount 0; oEmpty 1; oFull 0; oMemReq 0.
  - oMemAddr, oMemData and oMemByteEnable are 0.
  - An outstanding request is abandoned without waiting for iMemAck; memory must tolerate req dropping.
- Storage:
  - Circular FIFO with head and tail pointers of log2(DEPTH) bits; both wrap DEPTH-1 -> 0.
  - Each entry holds {addr[31:2], data[31:0], be[3:0]}.
- Accept:
  - oWrReady = !oFull, combinational from registered state only; there is no full-bypass.
  - Push occurs on iWrValid && oWrReady.
- Drop rules:
  - A handshake with iWrException=1 or iWrByteEnable=4'b0000 is consumed (counts as accepted), but creates no entry and leaves oCount unchanged.
- Memory side:
  - oMemReq = !oEmpty.
  - oMemAddr = {head.addr, 2'b00}; oMemData = head.data; oMemByteEnable = head.be.
  - All oMem* outputs are driven from registers and held stable while oMemReq && !iMemAck.
- Pop:
  - On oMemReq && iMemAck, the head advances at that edge.
  - The next entry is presented the following cycle, so back-to-back acks drain one entry per cycle.
  - iMemAck while oMemReq=0 is ignored.
- Latency:
  - A store pushed into an empty buffer appears on oMemReq/oMem* the next cycle.
  - No same-cycle pass-through.
- Simultaneous push and pop:
  - Both take effect; oCount is unchanged.
  - When oFull is 1, a pop frees a slot visible as oWrReady=1 only in the next cycle.
- oLdHit is combinational:
  - 1 when any valid entry has addr == iLdAddr[31:2], including the head currently being issued.
  - Byte-lane overlap is ignored (conservative).
  - Stores pushed in the current cycle do not contribute.
- oCount, oEmpty and oFull are registered-state-derived.
- Write ordering to memory is strictly FIFO.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined:
  - An accepted, non-dropped store merges into the youngest valid entry instead of allocating a slot, when both hold:
    - its word address equals that entry's address;
    - that entry is not the head (oCount >= 2).
  - Merge rule: for each lane set in iWrByteEnable, the entry's data byte is replaced by the iWrData byte; be |= iWrByteEnable.
  - oCount is unchanged.
  - oWrReady remains !oFull.
- Undefined:
  - Every accepted non-dropped store allocates its own entry.

Test Plan:
- Reset then idle -> oMemReq=0, oCount=0, oEmpty=1, oWrReady=1, oLdHit=0 for iLdAddr=0x100.
- Push {0x1004, 0xAABBCCDD, 4'b1111}, iMemAck held 0 -> next cycle oMemReq=1, oMemAddr=0x1004, outputs stable for 5 cycles; iMemAck=1 for one cycle -> oEmpty=1 the cycle after.
- DEPTH=4: push 4 stores with ack low -> oFull=1, oWrReady=0, and a 5th iWrValid is not accepted; one ack -> oWrReady=1 next cycle.
- Push sb at 0x2003 (data 0x5A5A5A5A, be 4'b1000) -> oMemAddr=0x2000, oMemByteEnable=4'b1000; iLdAddr=0x2001 -> oLdHit=1; iLdAddr=0x2004 -> oLdHit=0.
- Push with iWrException=1 and with be=4'b0000 -> handshake completes, oCount stays 0, oMemReq stays 0.
- Coalescing, macro defined: queue A at 0x3000, then B (0x3004, be 4'b0011, data 0x00001111), then C (0x3004, be 4'b1100, data 0x22220000) -> oCount=2; B's drained write is data 0x22221111, be 4'b1111. Macro undefined: same stimulus gives oCount=3.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the store formatting stage and the data-memory bus.
// Latency: an accepted store reaches oMemReq/oMem* on the next cycle; there is no same-cycle pass-through.
// Backpressure: oWrReady = !oFull from registered state only; the head write is held until iMemAck.
// Option: define STORE_BUFFER_COALESCE_EN to merge same-word stores into the youngest non-head entry.
module store_buffer #(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iWrValid,
   output logic          oWrReady,
   input  logic [31:0]   iWrAddr,
   input  logic [31:0]   iWrData,
   input  logic [3:0]    iWrByteEnable,
   input  logic          iWrException,
   output logic          oMemReq,
   input  logic          iMemAck,
   output logic [31:0]   oMemAddr,
   output logic [31:0]   oMemData,
   output logic [3:0]    oMemByteEnable,
   input  logic [31:0]   iLdAddr,
   output logic          oLdHit,
   output logic [CW-1:0] oCount,
   output logic          oEmpty,
   output logic          oFull
);
   localparam int PW = $clog2(DEPTH);

   logic [29:0]   ent_addr [DEPTH];
   logic [31:0]   ent_data [DEPTH];
   logic [3:0]    ent_be   [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic wr_hs;
   logic wr_drop;
   logic do_push;
   logic do_merge;
   logic do_alloc;
   logic do_pop;
   logic unused_bits;

   // The low address bits only select lanes, which the formatting stage already encoded in the byte enables.
   assign unused_bits = ^{iLdAddr[1:0], iWrAddr[1:0]};

   assign oCount   = count;
   assign oEmpty   = (count == '0);
   assign oFull    = (count == CW'(DEPTH));
   assign oWrReady = !oFull;

   // The head entry is never modified while it is being issued, so these stay stable until acked.
   assign oMemReq        = !oEmpty;
   assign oMemAddr       = {ent_addr[head], 2'b00};
   assign oMemData       = ent_data[head];
   assign oMemByteEnable = ent_be[head];

   // Faulting or lane-less stores are consumed by the handshake but never reach memory.
   assign wr_hs   = iWrValid && oWrReady;
   assign wr_drop = iWrException || (iWrByteEnable == 4'b0000);
   assign do_push = wr_hs && !wr_drop;
   assign do_pop  = oMemReq && iMemAck;

`ifdef STORE_BUFFER_COALESCE_EN
   logic [PW-1:0] youngest;
   assign youngest = tail - PW'(1);
   // Merging into the head is excluded because the head may already be on the bus.
   assign do_merge = do_push && (count >= CW'(2)) && (ent_addr[youngest] == iWrAddr[31:2]);
`else
   assign do_merge = 1'b0;
`endif
   assign do_alloc = do_push && !do_merge;

   // FIFO state: allocate at tail, optionally merge into youngest, retire head on ack.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] <= '0;
            ent_data[i] <= '0;
            ent_be[i]   <= '0;
         end
      end else begin
         if (do_alloc) begin
            ent_addr[tail] <= iWrAddr[31:2];
            ent_data[tail] <= iWrData;
            ent_be[tail]   <= iWrByteEnable;
            tail           <= tail + PW'(1);
         end
`ifdef STORE_BUFFER_COALESCE_EN
         if (do_merge) begin
            for (int b = 0; b < 4; b++) begin
               if (iWrByteEnable[b]) begin
                  ent_data[youngest][8*b +: 8] <= iWrData[8*b +: 8];
               end
            end
            ent_be[youngest] <= ent_be[youngest] | iWrByteEnable;
         end
`endif
         if (do_pop) begin
            head <= head + PW'(1);
         end
         case ({do_alloc, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Load hazard: any live entry on the same word, head included; lanes are deliberately ignored.
   always_comb begin
      logic [PW-1:0] off;
      oLdHit = 1'b0;
      off    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - head;
         if ((CW'(off) < count) && (ent_addr[i] == iLdAddr[31:2])) begin
            oLdHit = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a queue-based reference model checked every cycle.
// Latency: the model updates on the rising edge; outputs are compared on the falling edge.
// Backpressure: the model accepts only when it holds fewer than DEPTH stores.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          iCLK = 1'b0;
   logic          iRST;
   logic          iWrValid;
   logic          oWrReady;
   logic [31:0]   iWrAddr;
   logic [31:0]   iWrData;
   logic [3:0]    iWrByteEnable;
   logic          iWrException;
   logic          oMemReq;
   logic          iMemAck;
   logic [31:0]   oMemAddr;
   logic [31:0]   oMemData;
   logic [3:0]    oMemByteEnable;
   logic [31:0]   iLdAddr;
   logic          oLdHit;
   logic [CW-1:0] oCount;
   logic          oEmpty;
   logic          oFull;

   int total = 0;
   int bad   = 0;
   bit started = 0;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iWrValid(iWrValid), .oWrReady(oWrReady),
      .iWrAddr(iWrAddr), .iWrData(iWrData),
      .iWrByteEnable(iWrByteEnable), .iWrException(iWrException),
      .oMemReq(oMemReq), .iMemAck(iMemAck),
      .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemByteEnable(oMemByteEnable),
      .iLdAddr(iLdAddr), .oLdHit(oLdHit),
      .oCount(oCount), .oEmpty(oEmpty), .oFull(oFull)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: the buffer is just an ordered list of pending word writes.
   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ent_t;

   ent_t        q[$];
   ent_t        me;
   int          mn;
   logic        mpop;
   logic [31:0] mmask;

   function automatic logic model_hit(input logic [31:0] a);
      foreach (q[i]) if (q[i].addr == a[31:2]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge iCLK) begin
      if (iRST) begin
         q.delete();
      end else begin
         mn   = q.size();
         mpop = (mn != 0) && iMemAck;
         if (iWrValid && (mn < DEPTH) && !iWrException && (iWrByteEnable != 4'b0000)) begin
            me.addr = iWrAddr[31:2];
            me.data = iWrData;
            me.be   = iWrByteEnable;
`ifdef STORE_BUFFER_COALESCE_EN
            if ((mn >= 2) && (q[mn-1].addr == iWrAddr[31:2])) begin
               me    = q[mn-1];
               mmask = {{8{iWrByteEnable[3]}}, {8{iWrByteEnable[2]}},
                        {8{iWrByteEnable[1]}}, {8{iWrByteEnable[0]}}};
               me.data  = (me.data & ~mmask) | (iWrData & mmask);
               me.be    = me.be | iWrByteEnable;
               q[mn-1]  = me;
            end else begin
               q.push_back(me);
            end
`else
            q.push_back(me);
`endif
         end
         if (mpop) void'(q.pop_front());
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge iCLK) begin
      if (started) begin
         chk("m_count", 32'(oCount), 32'(q.size()));
         chk("m_empty", 32'(oEmpty), 32'(q.size() == 0));
         chk("m_full", 32'(oFull), 32'(q.size() == DEPTH));
         chk("m_ready", 32'(oWrReady), 32'(q.size() < DEPTH));
         chk("m_req", 32'(oMemReq), 32'(q.size() != 0));
         chk("m_ldhit", 32'(oLdHit), 32'(model_hit(iLdAddr)));
         if (q.size() != 0) begin
            chk("m_addr", oMemAddr, {q[0].addr, 2'b00});
            chk("m_data", oMemData, q[0].data);
            chk("m_be", 32'(oMemByteEnable), 32'(q[0].be));
         end
      end
   end

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      iWrValid = 1'b1; iWrAddr = a; iWrData = d; iWrByteEnable = be; iWrException = 1'b0;
      step();
      iWrValid = 1'b0;
   endtask

   task automatic drain();
      iMemAck = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (oEmpty) break;
      end
      iMemAck = 1'b0;
      chk("drain_empty", 32'(oEmpty), 32'd1);
   endtask

   initial begin
      iRST = 1'b1; iWrValid = 1'b0; iWrAddr = '0; iWrData = '0; iWrByteEnable = '0;
      iWrException = 1'b0; iMemAck = 1'b0; iLdAddr = 32'h100;
      step(); step();
      iRST = 1'b0;
      started = 1;

      // reset / idle
      @(negedge iCLK);
      chk("rst_req", 32'(oMemReq), 32'd0);
      chk("rst_count", 32'(oCount), 32'd0);
      chk("rst_empty", 32'(oEmpty), 32'd1);
      chk("rst_full", 32'(oFull), 32'd0);
      chk("rst_ready", 32'(oWrReady), 32'd1);
      chk("rst_ldhit", 32'(oLdHit), 32'd0);
      chk("rst_addr", oMemAddr, 32'd0);
      step();

      // single store, held through 5 cycles of no-ack
      push(32'h1004, 32'hAABBCCDD, 4'b1111);
      for (int k = 0; k < 5; k++) begin
         @(negedge iCLK);
         chk("hold_req", 32'(oMemReq), 32'd1);
         chk("hold_addr", oMemAddr, 32'h1004);
         chk("hold_data", oMemData, 32'hAABBCCDD);
         step();
      end
      iMemAck = 1'b1;
      step();
      iMemAck = 1'b0;
      @(negedge iCLK);
      chk("ack_empty", 32'(oEmpty), 32'd1);
      step();

      // fill to DEPTH, fifth store blocked until a slot frees
      for (int i = 0; i < 4; i++) push(32'h4000 + 32'(4 * i), 32'(i + 1), 4'b1111);
      @(negedge iCLK);
      chk("fill_full", 32'(oFull), 32'd1);
      chk("fill_ready", 32'(oWrReady), 32'd0);
      iWrValid = 1'b1; iWrAddr = 32'h5000; iWrData = 32'h55; iWrByteEnable = 4'b1111;
      step(); step();
      @(negedge iCLK);
      chk("full_block", 32'(oCount), 32'd4);
      iMemAck = 1'b1;
      step();
      iMemAck = 1'b0;
      @(negedge iCLK);
      chk("pop_ready", 32'(oWrReady), 32'd1);
      chk("pop_count", 32'(oCount), 32'd3);
      step();
      iWrValid = 1'b0;
      @(negedge iCLK);
      chk("refill_count", 32'(oCount), 32'd4);
      chk("refill_head", oMemAddr, 32'h4004);
      drain();

      // byte store and load-hit
      push(32'h2003, 32'h5A5A5A5A, 4'b1000);
      iLdAddr = 32'h2001;
      @(negedge iCLK);
      chk("sb_addr", oMemAddr, 32'h2000);
      chk("sb_be", 32'(oMemByteEnable), 32'h8);
      chk("ld_hit_same", 32'(oLdHit), 32'd1);
      iLdAddr = 32'h2004;
      #1;
      chk("ld_hit_next", 32'(oLdHit), 32'd0);
      iLdAddr = 32'h6000;
      iWrValid = 1'b1; iWrAddr = 32'h6000; iWrData = 32'h66; iWrByteEnable = 4'b0001;
      #1;
      chk("ld_hit_inflight", 32'(oLdHit), 32'd0);
      step();
      iWrValid = 1'b0;
      @(negedge iCLK);
      chk("ld_hit_queued", 32'(oLdHit), 32'd1);
      drain();

      // dropped handshakes
      iWrValid = 1'b1; iWrAddr = 32'h7000; iWrData = 32'h77; iWrByteEnable = 4'b1111; iWrException = 1'b1;
      @(negedge iCLK);
      chk("exc_ready", 32'(oWrReady), 32'd1);
      step();
      iWrException = 1'b0; iWrByteEnable = 4'b0000;
      step();
      iWrValid = 1'b0;
      @(negedge iCLK);
      chk("drop_count", 32'(oCount), 32'd0);
      chk("drop_req", 32'(oMemReq), 32'd0);
      step();

      // simultaneous push and pop
      push(32'h8000, 32'h80, 4'b1111);
      iWrValid = 1'b1; iWrAddr = 32'h8004; iWrData = 32'h84; iWrByteEnable = 4'b1111; iMemAck = 1'b1;
      step();
      iWrValid = 1'b0; iMemAck = 1'b0;
      @(negedge iCLK);
      chk("pp_count", 32'(oCount), 32'd1);
      chk("pp_addr", oMemAddr, 32'h8004);
      drain();

      // same-word stores behind a different head
      push(32'h3000, 32'h11111111, 4'b1111);
      push(32'h3004, 32'h00001111, 4'b0011);
      push(32'h3004, 32'h22220000, 4'b1100);
      @(negedge iCLK);
`ifdef STORE_BUFFER_COALESCE_EN
      chk("co_count", 32'(oCount), 32'd2);
`else
      chk("co_count", 32'(oCount), 32'd3);
`endif
      iMemAck = 1'b1;
      step();
      iMemAck = 1'b0;
      @(negedge iCLK);
      chk("co_addr", oMemAddr, 32'h3004);
`ifdef STORE_BUFFER_COALESCE_EN
      chk("co_data", oMemData, 32'h22221111);
      chk("co_be", 32'(oMemByteEnable), 32'hF);
`else
      chk("co_data", oMemData, 32'h00001111);
      chk("co_be", 32'(oMemByteEnable), 32'h3);
`endif
      drain();

      // reset abandons an outstanding request
      push(32'h9000, 32'h99, 4'b1111);
      iRST = 1'b1;
      step();
      iRST = 1'b0;
      @(negedge iCLK);
      chk("rst2_req", 32'(oMemReq), 32'd0);
      chk("rst2_count", 32'(oCount), 32'd0);
      chk("rst2_addr", oMemAddr, 32'd0);
      chk("rst2_data", oMemData, 32'd0);
      chk("rst2_be", 32'(oMemByteEnable), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
